// File: rtl/riscv_csrbus_if.sv
// -----------------------------------------------------------------------------
// riscv_csrbus_if
//   Downstream CSR bus between the requester arbiter and the CSR-bus adapter.
//   One transaction at a time: the master holds valid with stable command
//   fields until the slave answers with a single-cycle ready carrying rd_value
//   and error.
//
//   Signals
//     valid     master -> slave   command present
//     csr       master -> slave   12-bit CSR number
//     funct3    master -> slave   CSR opcode (CSRRW/CSRRS/CSRRC/...I)
//     rs1       master -> slave   rs1 field / zimm
//     rs1_value master -> slave   rs1 operand
//     ready     slave  -> master  completion strobe
//     rd_value  slave  -> master  read data, valid with ready
//     error     slave  -> master  error status, valid with ready
// -----------------------------------------------------------------------------
interface riscv_csrbus_if #(
   parameter int XLEN = 32
);

   logic            valid;
   logic [11:0]     csr;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [XLEN-1:0] rs1_value;
   logic            ready;
   logic [XLEN-1:0] rd_value;
   logic            error;

   modport master (
      output valid, csr, funct3, rs1, rs1_value,
      input  ready, rd_value, error
   );

   modport slave (
      input  valid, csr, funct3, rs1, rs1_value,
      output ready, rd_value, error
   );

endinterface

// File: rtl/rggen_riscv_csrbus_arbiter.sv
// -----------------------------------------------------------------------------
// rggen_riscv_csrbus_arbiter
//   Round-robin arbiter that funnels CSR accesses from several requesters onto
//   one downstream CSR bus. One transaction is outstanding at a time:
//     IDLE -> grant the first requester at/after the round-robin pointer and
//             latch its command fields
//     BUSY -> present the latched command downstream until ready, or until
//             TIMEOUT BUSY cycles elapse (forced error completion)
//     RESP -> pulse o_ready for the granted requester for one cycle
//
//   Parameters
//     REQUESTERS  number of requesters (2..8)
//     XLEN        CSR data width
//     TIMEOUT     BUSY-cycle limit before forced error completion, 0 = none
//
//   Ports
//     i_clk        clock, all state on the rising edge
//     i_rst_n      asynchronous active-low reset
//     i_valid      per-requester request
//     i_csr        per-requester CSR number        (REQUESTERS x 12)
//     i_funct3     per-requester CSR opcode        (REQUESTERS x 3)
//     i_rs1        per-requester rs1 field / zimm  (REQUESTERS x 5)
//     i_rs1_value  per-requester rs1 operand       (REQUESTERS x XLEN)
//     o_ready      per-requester completion strobe
//     o_rd_value   read data, shared, held outside RESP
//     o_error      error status, shared, held outside RESP
//     csrbus_if    downstream CSR bus (master side)
// -----------------------------------------------------------------------------
module rggen_riscv_csrbus_arbiter #(
   parameter int REQUESTERS = 2,
   parameter int XLEN       = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [REQUESTERS-1:0]      i_valid,
   input  logic [REQUESTERS*12-1:0]   i_csr,
   input  logic [REQUESTERS*3-1:0]    i_funct3,
   input  logic [REQUESTERS*5-1:0]    i_rs1,
   input  logic [REQUESTERS*XLEN-1:0] i_rs1_value,
   output logic [REQUESTERS-1:0]      o_ready,
   output logic [XLEN-1:0]            o_rd_value,
   output logic                       o_error,
   riscv_csrbus_if.master             csrbus_if
);

   localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [IDX_W-1:0]  pointer;
   logic [IDX_W-1:0]  grant;

   logic              grant_found;
   logic [IDX_W-1:0]  grant_sel;
   logic              hi_found;
   logic [IDX_W-1:0]  hi_sel;
   logic              lo_found;
   logic [IDX_W-1:0]  lo_sel;

   logic [11:0]       sel_csr;
   logic [2:0]        sel_funct3;
   logic [4:0]        sel_rs1;
   logic [XLEN-1:0]   sel_rs1_value;

   logic [11:0]       csr_q;
   logic [2:0]        funct3_q;
   logic [4:0]        rs1_q;
   logic [XLEN-1:0]   rs1_value_q;

   logic [CNT_W-1:0]  count;
   logic              timeout_hit;
   logic              bus_ready;

   // --------------------------------------------------------------------------
   // Round-robin selection. hi_* is the first request at or above the pointer,
   // lo_* the first request overall; when nothing sits at or above the pointer
   // the search wraps, and the lowest requesting index is the wrapped winner.
   // --------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned (which would infer a latch).
   always_comb begin
      hi_found = 1'b0;
      hi_sel   = '0;
      lo_found = 1'b0;
      lo_sel   = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (!hi_found && i_valid[i] && (IDX_W'(i) >= pointer)) begin
            hi_found = 1'b1;
            hi_sel   = IDX_W'(i);
         end
         if (!lo_found && i_valid[i]) begin
            lo_found = 1'b1;
            lo_sel   = IDX_W'(i);
         end
      end
      grant_found = hi_found | lo_found;
      grant_sel   = hi_found ? hi_sel : lo_sel;
   end

   // Command fields of the selected requester.
   always_comb begin
      sel_csr       = '0;
      sel_funct3    = '0;
      sel_rs1       = '0;
      sel_rs1_value = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (grant_sel == IDX_W'(i)) begin
            sel_csr       = i_csr[i*12 +: 12];
            sel_funct3    = i_funct3[i*3 +: 3];
            sel_rs1       = i_rs1[i*5 +: 5];
            sel_rs1_value = i_rs1_value[i*XLEN +: XLEN];
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   assign bus_ready = csrbus_if.ready;

   // count holds the number of BUSY cycles already spent without ready, so the
   // limit is reached in the TIMEOUT-th BUSY cycle. Ready in that same cycle
   // still wins because the BUSY branches test ready first.
   assign timeout_hit = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (grant_found)              state_next = BUSY;
         BUSY: if (bus_ready || timeout_hit) state_next = RESP;
         RESP:                               state_next = IDLE;
         default:                            state_next = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath: pointer, grant, latched command, timeout counter, response.
   // --------------------------------------------------------------------------
   // NOTE: the latched command is a handful of flops, not a memory, so it is
   // cleared on reset like every other register here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pointer     <= '0;
         grant       <= '0;
         csr_q       <= '0;
         funct3_q    <= '0;
         rs1_q       <= '0;
         rs1_value_q <= '0;
         count       <= '0;
         o_rd_value  <= '0;
         o_error     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant       <= grant_sel;
                  pointer     <= (grant_sel == IDX_W'(REQUESTERS - 1)) ? '0
                                                                      : grant_sel + 1'b1;
                  csr_q       <= sel_csr;
                  funct3_q    <= sel_funct3;
                  rs1_q       <= sel_rs1;
                  rs1_value_q <= sel_rs1_value;
                  count       <= '0;
               end
            end
            BUSY: begin
               if (bus_ready) begin
                  o_rd_value <= csrbus_if.rd_value;
                  o_error    <= csrbus_if.error;
               end else if (timeout_hit) begin
                  o_rd_value <= '0;
                  o_error    <= 1'b1;
               end else if (count != '1) begin
                  count <= count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs. valid is decoded from state so reset removes it immediately.
   // --------------------------------------------------------------------------
   assign csrbus_if.valid     = (state == BUSY);
   assign csrbus_if.csr       = csr_q;
   assign csrbus_if.funct3    = funct3_q;
   assign csrbus_if.rs1       = rs1_q;
   assign csrbus_if.rs1_value = rs1_value_q;

   always_comb begin
      o_ready = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if ((state == RESP) && (grant == IDX_W'(i))) begin
            o_ready[i] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rggen_riscv_csrbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rggen_riscv_csrbus_arbiter
//   Directed bench for the CSR-bus arbiter with three requesters and TIMEOUT=4.
//   A downstream responder answers after a programmable number of valid cycles
//   (or never) and drives junk data while not ready. Outputs are sampled one
//   time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_rggen_riscv_csrbus_arbiter;

   localparam int N  = 3;
   localparam int XL = 32;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    valid;
   logic [N*12-1:0] csr;
   logic [N*3-1:0]  funct3;
   logic [N*5-1:0]  rs1;
   logic [N*XL-1:0] rs1_value;
   logic [N-1:0]    ready;
   logic [XL-1:0]   rd_value;
   logic            error;

   riscv_csrbus_if #(.XLEN(XL)) bus ();

   rggen_riscv_csrbus_arbiter #(
      .REQUESTERS (N),
      .XLEN       (XL),
      .TIMEOUT    (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (valid),
      .i_csr       (csr),
      .i_funct3    (funct3),
      .i_rs1       (rs1),
      .i_rs1_value (rs1_value),
      .o_ready     (ready),
      .o_rd_value  (rd_value),
      .o_error     (error),
      .csrbus_if   (bus)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checking
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ downstream responder
   int          resp_delay = 1;
   logic [31:0] resp_data  = '0;
   logic        resp_err   = 1'b0;
   bit          resp_never = 1'b0;

   int          busy_cycles   = 0;
   int          last_busy_len = 0;
   int          field_changes = 0;
   logic [11:0] cap_csr;
   logic [2:0]  cap_f3;
   logic [4:0]  cap_rs1;
   logic [31:0] cap_val;

   always @(negedge clk) begin
      if (bus.valid) begin
         busy_cycles++;
         if (busy_cycles == 1) begin
            cap_csr = bus.csr;
            cap_f3  = bus.funct3;
            cap_rs1 = bus.rs1;
            cap_val = bus.rs1_value;
         end else if (bus.csr !== cap_csr || bus.funct3 !== cap_f3 ||
                      bus.rs1 !== cap_rs1 || bus.rs1_value !== cap_val) begin
            field_changes++;
         end
         if (!resp_never && busy_cycles == resp_delay) begin
            bus.ready    = 1'b1;
            bus.rd_value = resp_data;
            bus.error    = resp_err;
         end else begin
            bus.ready    = 1'b0;
            bus.rd_value = 32'hDEAD_BEEF;
            bus.error    = 1'b1;
         end
      end else begin
         if (busy_cycles != 0) last_busy_len = busy_cycles;
         busy_cycles  = 0;
         bus.ready    = 1'b0;
         bus.rd_value = 32'hDEAD_BEEF;
         bus.error    = 1'b0;
      end
   end

   // ------------------------------------------------------- requester monitor
   int          pulses        = 0;
   int          double_pulses = 0;
   logic [N-1:0] last_ready   = '0;
   logic [N-1:0] prev_ready   = '0;
   logic [31:0] last_rd       = '0;
   logic        last_err      = 1'b0;

   always @(negedge clk) begin
      if (ready != '0) begin
         pulses++;
         last_ready = ready;
         last_rd    = rd_value;
         last_err   = error;
         if (prev_ready != '0) double_pulses++;
      end
      prev_ready = ready;
   end

   // ------------------------------------------------------------------ helpers
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_req(input int r, input logic [11:0] c, input logic [2:0] f,
                          input logic [4:0] s, input logic [31:0] v);
      valid[r]               = 1'b1;
      csr[r*12 +: 12]        = c;
      funct3[r*3 +: 3]       = f;
      rs1[r*5 +: 5]          = s;
      rs1_value[r*XL +: XL]  = v;
   endtask

   task automatic wait_pulse(input string tag, input int max_cycles, output int cycles);
      int start;
      start  = pulses;
      cycles = 0;
      while (pulses == start && cycles < max_cycles) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      check({tag, "_pulse"}, 64'(pulses - start), 64'd1);
   endtask

   // ------------------------------------------------------------------- stimulus
   int cyc;
   int pulses_before;
   int waited;

   initial begin
      valid     = '0;
      csr       = '0;
      funct3    = '0;
      rs1       = '0;
      rs1_value = '0;

      // Reset state
      step(3);
      check("rst_ready",     64'(ready),         64'd0);
      check("rst_rd",        64'(rd_value),      64'd0);
      check("rst_err",       64'(error),         64'd0);
      check("rst_bus_valid", 64'(bus.valid),     64'd0);
      check("rst_bus_csr",   64'(bus.csr),       64'd0);
      check("rst_bus_val",   64'(bus.rs1_value), 64'd0);
      rst_n = 1'b1;
      step(1);

      // Single request, ready in the 2nd valid cycle
      resp_delay = 2; resp_data = 32'hAA; resp_err = 1'b0; resp_never = 1'b0;
      set_req(0, 12'h300, 3'b001, 5'd5, 32'h1234);
      wait_pulse("single", 20, cyc);
      check("single_latency", 64'(cyc),       64'd3);
      check("single_ready",   64'(last_ready), 64'b001);
      check("single_rd",      64'(last_rd),    64'hAA);
      check("single_err",     64'(last_err),   64'd0);
      check("single_csr",     64'(cap_csr),    64'h300);
      check("single_funct3",  64'(cap_f3),     64'd1);
      check("single_rs1",     64'(cap_rs1),    64'd5);
      check("single_rs1val",  64'(cap_val),    64'h1234);
      valid[0] = 1'b0;
      step(2);
      check("single_busy_len", 64'(last_busy_len), 64'd2);
      check("single_idle_rdy", 64'(ready),         64'd0);
      check("single_hold_rd",  64'(rd_value),      64'hAA);

      // Error passthrough on requester 1
      resp_data = 32'h77; resp_err = 1'b1;
      set_req(1, 12'h301, 3'b010, 5'd7, 32'h55);
      wait_pulse("err", 20, cyc);
      check("err_ready", 64'(last_ready), 64'b010);
      check("err_err",   64'(last_err),   64'd1);
      check("err_rd",    64'(last_rd),    64'h77);
      check("err_csr",   64'(cap_csr),    64'h301);
      valid[1] = 1'b0;
      step(2);
      check("err_hold", 64'(error), 64'd1);

      // Pointer at 2, requests from 0 and 1: wrap to 0, then 1
      resp_err = 1'b0; resp_delay = 1; resp_data = 32'h10;
      set_req(0, 12'h340, 3'b011, 5'd1, 32'hA0);
      set_req(1, 12'h341, 3'b101, 5'd2, 32'hB1);
      wait_pulse("wrap0", 20, cyc);
      check("wrap0_ready",  64'(last_ready), 64'b001);
      check("wrap0_rs1val", 64'(cap_val),    64'hA0);
      check("wrap0_err",    64'(last_err),   64'd0);
      valid[0]  = 1'b0;
      resp_data = 32'h11;
      wait_pulse("wrap1", 20, cyc);
      check("wrap1_ready",  64'(last_ready), 64'b010);
      check("wrap1_rs1val", 64'(cap_val),    64'hB1);
      check("wrap1_csr",    64'(cap_csr),    64'h341);
      check("wrap1_rd",     64'(last_rd),    64'h11);
      valid[1] = 1'b0;
      step(2);

      // Timeout: downstream never ready
      resp_never = 1'b1;
      set_req(2, 12'hC00, 3'b110, 5'd3, 32'h3);
      wait_pulse("tmo", 20, cyc);
      check("tmo_latency", 64'(cyc),        64'd5);
      check("tmo_ready",   64'(last_ready), 64'b100);
      check("tmo_err",     64'(last_err),   64'd1);
      check("tmo_rd",      64'(last_rd),    64'd0);
      valid[2] = 1'b0;
      step(1);
      check("tmo_busy_len", 64'(last_busy_len), 64'd4);
      step(1);

      // Ready exactly at the timeout limit completes normally
      resp_never = 1'b0; resp_delay = TO; resp_data = 32'h5A;
      set_req(1, 12'h342, 3'b001, 5'd9, 32'h99);
      wait_pulse("limit", 20, cyc);
      check("limit_ready", 64'(last_ready), 64'b010);
      check("limit_err",   64'(last_err),   64'd0);
      check("limit_rd",    64'(last_rd),    64'h5A);
      valid[1] = 1'b0;
      step(1);
      check("limit_busy_len", 64'(last_busy_len), 64'd4);
      step(1);

      // Reset in the middle of BUSY, then contention from reset
      resp_never = 1'b1;
      set_req(0, 12'h305, 3'b001, 5'd4, 32'hC0);
      waited = 0;
      while (!bus.valid && waited < 10) begin
         step(1);
         waited++;
      end
      check("rb_valid_seen", 64'(bus.valid), 64'd1);
      pulses_before = pulses;
      #2;
      rst_n = 1'b0;
      #1;
      check("rb_async_valid", 64'(bus.valid), 64'd0);
      check("rb_async_ready", 64'(ready),     64'd0);
      check("rb_async_csr",   64'(bus.csr),   64'd0);
      set_req(1, 12'h306, 3'b010, 5'd6, 32'hC1);
      resp_never = 1'b0; resp_delay = 1; resp_data = 32'h42;
      step(2);
      rst_n = 1'b1;
      check("rb_no_pulse", 64'(pulses - pulses_before), 64'd0);
      wait_pulse("cont0", 20, cyc);
      check("cont0_ready",  64'(last_ready), 64'b001);
      check("cont0_rs1val", 64'(cap_val),    64'hC0);
      wait_pulse("cont1", 20, cyc);
      check("cont1_ready",  64'(last_ready), 64'b010);
      check("cont1_rs1val", 64'(cap_val),    64'hC1);
      wait_pulse("cont2", 20, cyc);
      check("cont2_ready",  64'(last_ready), 64'b001);
      wait_pulse("cont3", 20, cyc);
      check("cont3_ready",  64'(last_ready), 64'b010);
      valid = '0;
      step(3);
      check("one_cycle_ready", 64'(double_pulses), 64'd0);
      check("fields_stable",   64'(field_changes), 64'd0);
      check("idle_bus_valid",  64'(bus.valid),     64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/rggen_riscv_csrbus_arbiter.md
RGGEN_RISCV_CSRBUS_ARBITER -- requirements
Module: rggen_riscv_csrbus_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 2, number of CSR-bus requesters (2..8).
REQ-002 SHALL have parameter XLEN, default 32, CSR data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, BUSY-cycle limit before forced error completion; 0 disables timeout.
REQ-004 SHALL have port i_clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid, input, REQUESTERS, per-requester request.
REQ-007 SHALL have port i_csr, input, REQUESTERS*12, per-requester CSR number.
REQ-008 SHALL have port i_funct3, input, REQUESTERS*3, per-requester CSR opcode.
REQ-009 SHALL have port i_rs1, input, REQUESTERS*5, per-requester rs1 field / zimm.
REQ-010 SHALL have port i_rs1_value, input, REQUESTERS*XLEN, per-requester rs1 operand.
REQ-011 SHALL have port o_ready, output, REQUESTERS, per-requester completion strobe.
REQ-012 SHALL have port o_rd_value, output, XLEN, read data, shared by all requesters.
REQ-013 SHALL have port o_error, output, 1, error status, shared by all requesters.
REQ-014 SHALL have port csrbus_if, riscv_csrbus_if.master, downstream CSR bus to the CSR-bus adapter.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: SHALL grant, when any i_valid is high, the first requester at or after the round-robin pointer (wrapping REQUESTERS-1 -> 0), latch its csr/funct3/rs1/rs1_value and index, then go to BUSY.
REQ-017 SHALL set the pointer to grant index + 1 (mod REQUESTERS) on each grant; ungranted requests wait with no loss.
REQ-018 BUSY: SHALL drive csrbus_if.valid=1 with the latched fields, which stay stable until exit.
REQ-019 BUSY with csrbus_if.ready=1: SHALL register rd_value and error into o_rd_value and o_error, then go to RESP.
REQ-020 BUSY with TIMEOUT!=0 and no ready after TIMEOUT cycles: SHALL drop valid, set o_rd_value=0 and o_error=1, then go to RESP.
REQ-021 Ready on the same cycle as the timeout limit SHALL count as a normal completion.
REQ-022 RESP: SHALL assert o_ready[grant] for exactly one cycle with o_rd_value and o_error valid, then go to IDLE.
REQ-023 Requester contract: i_valid held with stable fields until o_ready, then deasserted on the next cycle; i_valid drops before o_ready SHALL NOT abort the transaction.
REQ-024 Latency: grant at IDLE cycle t -> csrbus valid at t+1; downstream ready at cycle k -> o_ready at k+1; minimum 3 cycles request-to-o_ready.
REQ-025 Only one transaction SHALL be outstanding; csrbus_if.valid=0 in IDLE and RESP.
REQ-026 The timeout counter SHALL be $clog2(TIMEOUT+1) bits, cleared on entry to BUSY, and saturate without wrap.
REQ-027 o_rd_value and o_error SHALL hold their last values outside RESP.

Reset
REQ-028 On i_rst_n=0: state=IDLE, pointer=0, o_ready=0, csrbus_if.valid=0, o_rd_value=0, o_error=0, counter=0, latched fields=0, immediately and asynchronously.
REQ-029 Reset during BUSY or RESP SHALL abandon the transaction with no o_ready pulse; first grant after release goes to requester 0 if requesting.

Verification
REQ-030 Single request: req0 CSRRW csr=0x300 rs1_value=0x1234, downstream ready after 2 cycles with rd=0xAA -> one csrbus access with identical fields, o_ready=01 for one cycle, o_rd_value=0xAA, o_error=0.
REQ-031 Contention: req0 and req1 both valid continuously from reset for 4 transactions -> grant order 0,1,0,1, no request dropped.
REQ-032 Error passthrough: downstream ready with error=1 -> o_error=1 in the o_ready cycle for the granted requester only.
REQ-033 Timeout: TIMEOUT=4, downstream never ready -> valid high exactly 4 cycles, then o_ready pulse with o_error=1, o_rd_value=0; next request served normally.
REQ-034 Reset mid-BUSY: assert i_rst_n=0 while csrbus valid=1 -> valid=0 with no clock edge, no o_ready pulse, pointer=0 after release.
REQ-035 Boundary: REQUESTERS=3, pointer=2, requests from 0 and 1 -> grant 0 (wrap), then 1.
